xbitshifter_mc: RTL and testbench
=================================

Name: xbitshifter_mc

Overview:
- Parametrised successor to the single-bit variable-delay shifter: a WIDTH-bit lane delayed by a programmable number of accepted samples, 0..MAX_LEN.
- Delay length is controlled by inc/dec one-shot pulses from the debounce/one-shot filters, or by a direct load.
- Samples advance only on in_valid (stall-tolerant), rather than every clock.
- out_valid marks output samples whose source was actually captured since reset, not a reset-filled slot.

Parameters:
- WIDTH, 1, data lane width in bits (>=1).
- MAX_LEN, 15, maximum delay in accepted samples (>=0).
- WRAP, 1, 1: len wraps at both limits; 0: len saturates at both limits.
- RES_INIT, 0, reset value of every bit of out_data (0 or 1).
- LEN_W, derived, $clog2(MAX_LEN+1), minimum 1; not user-set.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_data is accepted this cycle.
- in_data  in  WIDTH  sample data.
- inc_pulse  in  1  1-cycle pulse, len+1.
- dec_pulse  in  1  1-cycle pulse, len-1.
- load  in  1  load len from load_len.
- load_len  in  LEN_W  new delay value.
- out_data  out  WIDTH  delayed sample (registered).
- out_valid  out  1  1-cycle strobe: out_data updated with a real sample.
- len  out  LEN_W  current delay setting (registered).

Behaviour:
- Reset, sampled on clk when rst_n=0:
  - len=0, out_data={WIDTH{RES_INIT}}, out_valid=0.
  - Input stage and shift chain cleared to 0; fill=0.
  - Reset overrides every other input, including mid-stream.
- Input stage: in_reg<=in_data and v_d<=in_valid every cycle.
- Shift chain:
  - Sample array pipe[0..MAX_LEN], with pipe[0]=in_reg and pipe[k]=chain[k-1].
  - Shifts by one only when v_d=1; holds otherwise.
- Output:
  - When v_d=1: out_data<=pipe[len] and out_valid<=(fill>=len). fill is the value before this sample is counted.
  - When v_d=0: out_valid<=0 and out_data holds.
  - Latency: sample accepted at cycle t with len=L reaches out_data at t+2, delayed by exactly L further accepted samples.
- Fill counter:
  - fill<=min(fill+1, MAX_LEN) on each v_d=1.
  - Saturating, LEN_W bits, cleared only by reset.
  - len changes do not clear fill. Retained chain contents are real data, so raising len exposes older genuine samples.
- len control (evaluated each cycle, priority high to low):
  - load=1: len<=min(load_len, MAX_LEN). inc/dec are ignored.
  - inc_pulse & dec_pulse: no change.
  - inc_pulse at len<MAX_LEN: len+1. At len=MAX_LEN: WRAP=1 gives 0, WRAP=0 holds MAX_LEN.
  - dec_pulse at len>0: len-1. At len=0: WRAP=1 gives MAX_LEN, WRAP=0 holds 0.
  - A new len first selects pipe on the cycle after it is registered. A v_d in the same cycle as the control pulse uses the old len.
- Arithmetic: only ±1 on len and +1 on fill; no subtractor on the data path.
- MAX_LEN=0:
  - Chain is absent; len is constant 0; inc/dec/load have no effect.
  - out_valid=v_d after reset.
- MAX_LEN=1: chain is a single WIDTH-bit register.
- in_valid held low: out_data, chain and fill are frozen indefinitely; len still responds to controls.

Test Plan:
- Reset, then in_valid=1 for 20 cycles with in_data=1..20 (WIDTH=8, len=0) -> out_data=1..20, each 2 cycles after its input; out_valid=1 throughout.
- Apply 3 inc_pulses, then stream 1..10 -> out_data shows 0,0,0 with out_valid=0, then 1..7 with out_valid=1 (delay of 3 samples).
- Wrap/saturate, MAX_LEN=15 -> WRAP=1: 16 inc_pulses from 0 give len=0, one dec at 0 gives 15. WRAP=0: len stops at 15, and dec at 0 stays 0.
- load=1, load_len=5 together with inc_pulse=1 -> len=5. load_len=15 with MAX_LEN=12 -> len=12. inc&dec together at len=4 -> len=4.
- Stall, len=2, stream A,B,C then in_valid=0 for 7 cycles then D,E -> out_data frozen at its last value during the stall with out_valid=0; output sequence resumes as B then C on D and E.
- rst_n=0 for 1 cycle mid-stream at len=6 -> next cycle len=0, out_data=RES_INIT pattern, out_valid=0, and the first post-reset sample appears at t+2.

Source files
------------

// File: rtl/xbitshifter_mc_if.sv
// Bus bundle for xbitshifter_mc: sample stream in/out plus delay-length control.
// MAX_LEN sizes the length fields exactly as the shifter does.
interface xbitshifter_mc_if #(
    parameter int WIDTH   = 1,
    parameter int MAX_LEN = 15
);
    localparam int LEN_W = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);

    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             inc_pulse;
    logic             dec_pulse;
    logic             load;
    logic [LEN_W-1:0] load_len;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [LEN_W-1:0] len;

    modport master (
        output in_valid, in_data, inc_pulse, dec_pulse, load, load_len,
        input  out_data, out_valid, len
    );

    modport slave (
        input  in_valid, in_data, inc_pulse, dec_pulse, load, load_len,
        output out_data, out_valid, len
    );
endinterface

// File: rtl/xbitshifter_mc.sv
// WIDTH-bit lane delayed by 0..MAX_LEN accepted samples; the chain advances only
// on valid input, and out_valid flags outputs whose source sample was really captured.
module xbitshifter_mc #(
    parameter int WIDTH    = 1,
    parameter int MAX_LEN  = 15,
    parameter int WRAP     = 1,
    parameter int RES_INIT = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    xbitshifter_mc_if.slave    bus
);
    localparam int LEN_W = (MAX_LEN < 1) ? 1 : $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [WIDTH-1:0] RES_WORD = {WIDTH{RES_INIT[0]}};

    logic [WIDTH-1:0] in_reg;
    logic             v_d;
    logic [WIDTH-1:0] pipe [0:MAX_LEN];
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_next;
    logic [LEN_W-1:0] fill;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_reg <= '0;
            v_d    <= 1'b0;
        end else begin
            in_reg <= bus.in_data;
            v_d    <= bus.in_valid;
        end
    end

    generate
        if (MAX_LEN > 0) begin : g_chain
            logic [WIDTH-1:0] chain [0:MAX_LEN-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < MAX_LEN; k++) chain[k] <= '0;
                end else if (v_d) begin
                    chain[0] <= in_reg;
                    for (int k = 1; k < MAX_LEN; k++) chain[k] <= chain[k-1];
                end
            end

            always_comb begin
                pipe[0] = in_reg;
                for (int k = 1; k <= MAX_LEN; k++) pipe[k] = chain[k-1];
            end
        end else begin : g_direct
            always_comb pipe[0] = in_reg;
        end
    endgenerate

    // Load beats the pulses; a simultaneous inc and dec cancel out.
    always_comb begin
        len_next = len_q;
        if (bus.load) begin
            len_next = (bus.load_len > LEN_MAX) ? LEN_MAX : bus.load_len;
        end else if (bus.inc_pulse && bus.dec_pulse) begin
            len_next = len_q;
        end else if (bus.inc_pulse) begin
            if (len_q == LEN_MAX) len_next = (WRAP != 0) ? '0 : LEN_MAX;
            else                  len_next = len_q + LEN_W'(1);
        end else if (bus.dec_pulse) begin
            if (len_q == '0) len_next = (WRAP != 0) ? LEN_MAX : '0;
            else             len_next = len_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) len_q <= '0;
        else        len_q <= len_next;
    end

    // fill is compared before it counts the current sample, so a slot is real
    // once at least len samples have preceded it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= RES_WORD;
            out_valid_q <= 1'b0;
            fill        <= '0;
        end else if (v_d) begin
            out_data_q  <= pipe[len_q];
            out_valid_q <= (fill >= len_q);
            fill        <= (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.len       = len_q;
endmodule

// File: tb/tb_xbitshifter_mc.sv
// Directed scoreboard bench for xbitshifter_mc: four instances (wrap, saturate,
// MAX_LEN=12, MAX_LEN=0) share one stimulus stream.
module tb_xbitshifter_mc;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       load;
    logic [3:0] load_len;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       vld;
        logic       a_valid;
        logic [7:0] a_data;
        logic [3:0] z_data;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] hist [$];
    int         len_a, len_b, len_c, len_z;
    logic [7:0] last_a;
    logic [3:0] last_z;

    always #5 clk = ~clk;

    xbitshifter_mc_if #(.WIDTH(8), .MAX_LEN(15)) ifa ();
    xbitshifter_mc_if #(.WIDTH(8), .MAX_LEN(15)) ifb ();
    xbitshifter_mc_if #(.WIDTH(8), .MAX_LEN(12)) ifc ();
    xbitshifter_mc_if #(.WIDTH(4), .MAX_LEN(0))  ifz ();

    assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
    assign ifc.in_valid = in_valid;  assign ifz.in_valid = in_valid;
    assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;
    assign ifc.in_data  = in_data;   assign ifz.in_data  = in_data[3:0];
    assign ifa.inc_pulse = inc_pulse; assign ifb.inc_pulse = inc_pulse;
    assign ifc.inc_pulse = inc_pulse; assign ifz.inc_pulse = inc_pulse;
    assign ifa.dec_pulse = dec_pulse; assign ifb.dec_pulse = dec_pulse;
    assign ifc.dec_pulse = dec_pulse; assign ifz.dec_pulse = dec_pulse;
    assign ifa.load = load;  assign ifb.load = load;
    assign ifc.load = load;  assign ifz.load = load;
    assign ifa.load_len = load_len;  assign ifb.load_len = load_len;
    assign ifc.load_len = load_len;  assign ifz.load_len = load_len[0];

    xbitshifter_mc #(.WIDTH(8), .MAX_LEN(15), .WRAP(1), .RES_INIT(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    xbitshifter_mc #(.WIDTH(8), .MAX_LEN(15), .WRAP(0), .RES_INIT(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    xbitshifter_mc #(.WIDTH(8), .MAX_LEN(12), .WRAP(1), .RES_INIT(0)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    xbitshifter_mc #(.WIDTH(4), .MAX_LEN(0),  .WRAP(1), .RES_INIT(0)) dut_z (.clk(clk), .rst_n(rst_n), .bus(ifz));

    function automatic int next_len(input int l, input logic i, input logic dc,
                                    input logic ld, input int ll, input int mx, input int wr);
        if (ld)       return (ll > mx) ? mx : ll;
        if (i && dc)  return l;
        if (i)        return (l == mx) ? ((wr != 0) ? 0 : mx) : l + 1;
        if (dc)       return (l == 0) ? ((wr != 0) ? mx : 0) : l - 1;
        return l;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_lens();
        check_output("len_a", 32'(ifa.len), 32'(len_a));
        check_output("len_b", 32'(ifb.len), 32'(len_b));
        check_output("len_c", 32'(ifc.len), 32'(len_c));
        check_output("len_z", 32'(ifz.len), 32'(len_z));
    endtask

    // One clock of stimulus: model the output this input will produce two
    // edges later, queue it, then compare whatever is due now.
    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic i,
                                  input logic dc, input logic ld, input logic [3:0] ll);
        exp_t e;
        int   prev;
        in_valid = v; in_data = d; inc_pulse = i; dec_pulse = dc; load = ld; load_len = ll;
        len_a = next_len(len_a, i, dc, ld, int'(ll), 15, 1);
        len_b = next_len(len_b, i, dc, ld, int'(ll), 15, 0);
        len_c = next_len(len_c, i, dc, ld, int'(ll), 12, 1);
        len_z = next_len(len_z, i, dc, ld, int'(ll), 0, 1);
        e.vld = v;
        if (v) begin
            prev = hist.size();
            hist.push_back(d);
            e.a_valid = (prev >= len_a);
            e.a_data  = e.a_valid ? hist[prev - len_a] : 8'h00;
            e.z_data  = d[3:0];
        end else begin
            e.a_valid = 1'b0;
            e.a_data  = last_a;
            e.z_data  = last_z;
        end
        last_a = e.a_data;
        last_z = e.z_data;
        exp_q.push_back(e);
        @(negedge clk);
        check_lens();
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            check_output("a_out_data",  32'(ifa.out_data),  32'(e.a_data));
            check_output("a_out_valid", 32'(ifa.out_valid), 32'(e.a_valid));
            check_output("z_out_data",  32'(ifz.out_data),  32'(e.z_data));
            check_output("z_out_valid", 32'(ifz.out_valid), 32'(e.vld));
        end
    endtask

    // Reset with valid data and an inc pulse present to show reset wins.
    task automatic do_reset(input logic [7:0] d);
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b1; in_data = d;
        inc_pulse = 1'b1; dec_pulse = 1'b0; load = 1'b0; load_len = 4'd0;
        @(negedge clk);
        len_a = 0; len_b = 0; len_c = 0; len_z = 0;
        check_lens();
        check_output("rst_a_data",  32'(ifa.out_data),  32'h00);
        check_output("rst_a_valid", 32'(ifa.out_valid), 32'h0);
        check_output("rst_b_data",  32'(ifb.out_data),  32'hFF);
        check_output("rst_b_valid", 32'(ifb.out_valid), 32'h0);
        check_output("rst_c_data",  32'(ifc.out_data),  32'h00);
        check_output("rst_z_data",  32'(ifz.out_data),  32'h0);
        check_output("rst_z_valid", 32'(ifz.out_valid), 32'h0);
        rst_n = 1'b1;
        exp_q.delete();
        hist.delete();
        last_a = 8'h00;
        last_z = 4'h0;
        e.vld = 1'b0; e.a_valid = 1'b0; e.a_data = 8'h00; e.z_data = 4'h0;
        exp_q.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        inc_pulse = 1'b0; dec_pulse = 1'b0; load = 1'b0; load_len = 4'd0;
        len_a = 0; len_b = 0; len_c = 0; len_z = 0;
        last_a = 8'h00; last_z = 4'h0;

        $display("[TB] reset and zero-delay stream");
        do_reset(8'h00);
        for (int k = 1; k <= 20; k++) apply_stimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (3) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("[TB] delay of three after fresh reset");
        do_reset(8'h00);
        repeat (3) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        check_output("len_after_3inc", 32'(ifa.len), 32'd3);
        for (int k = 1; k <= 10; k++) apply_stimulus(1'b1, 8'(k), 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("[TB] wrap versus saturate");
        do_reset(8'h00);
        repeat (16) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'd0);
        check_output("wrap_inc16", 32'(ifa.len), 32'd0);
        check_output("sat_inc16",  32'(ifb.len), 32'd15);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        check_output("wrap_dec0", 32'(ifa.len), 32'd15);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0);
        check_output("sat_dec0", 32'(ifb.len), 32'd0);

        $display("[TB] load priority and clamp");
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 4'd5);
        check_output("load_over_inc", 32'(ifa.len), 32'd5);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd15);
        check_output("load_clamp12", 32'(ifc.len), 32'd12);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4);
        apply_stimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 4'd0);
        check_output("inc_dec_cancel", 32'(ifa.len), 32'd4);

        $display("[TB] stall with delay two");
        do_reset(8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd2);
        apply_stimulus(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (7) apply_stimulus(1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'hD4, 1'b0, 1'b0, 1'b0, 4'd0);
        apply_stimulus(1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("[TB] reset mid-stream at delay six");
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd6);
        for (int k = 0; k < 8; k++) apply_stimulus(1'b1, 8'(8'h31 + k), 1'b0, 1'b0, 1'b0, 4'd0);
        do_reset(8'h99);
        for (int k = 0; k < 4; k++) apply_stimulus(1'b1, 8'(8'h51 + k), 1'b0, 1'b0, 1'b0, 4'd0);
        repeat (2) apply_stimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
